// File: rtl/apb_slave_mem.sv
// apb_slave_mem: memory-backed APB4 completer with programmable wait states.
// Ports:
//   pclk, presetn            clock, asynchronous active-low reset
//   paddr, psel, penable     APB address / select / access phase
//   pwrite, pwdata, pstrb    direction, write data, byte strobes
//   prdata, pready, pslverr  read data, transfer complete, transfer error
// Reads are captured at the setup edge; writes are committed on the
// completion edge. Outputs decode from registered state only.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned ALIGN  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W  = ADDR_WIDTH - ALIGN;
  localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_r;
  logic                  err_r;
  logic [MIDX_W-1:0]     idx_r;
  logic [DATA_WIDTH-1:0] prdata_r;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Setup-phase address decode
  logic [IDX_W-1:0] idx_c;
  logic             misalign_c;
  logic             range_c;
  logic             err_c;
  logic             setup_c;
  logic             done_c;

  assign idx_c      = paddr[ADDR_WIDTH-1:ALIGN];
  // Mask form keeps this valid when there is a single byte lane
  assign misalign_c = (paddr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
  assign range_c    = 32'(idx_c) >= MEM_DEPTH;
  assign err_c      = misalign_c || range_c;
  assign setup_c    = (state == IDLE) && psel && !penable;
  assign done_c     = (state == ACCESS) && (cnt == '0) && psel && penable;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; dropping psel during ACCESS aborts the transfer
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (setup_c) state_nxt = ACCESS;
      ACCESS: begin
        if (!psel)                          state_nxt = IDLE;
        else if ((cnt == '0) && penable)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer context captured at setup, wait counter in ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt      <= '0;
      wr_r     <= 1'b0;
      err_r    <= 1'b0;
      idx_r    <= '0;
      prdata_r <= '0;
    end else if (setup_c) begin
      cnt   <= CNT_W'(WAIT_STATES);
      wr_r  <= pwrite;
      err_r <= err_c;
      idx_r <= MIDX_W'(idx_c);
      if (!pwrite) prdata_r <= err_c ? '0 : mem[MIDX_W'(idx_c)];
    end else if ((state == ACCESS) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Byte-strobed write on the completion edge
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else if (done_c && wr_r && !err_r) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++)
        if (pstrb[i]) mem[idx_r][8*i +: 8] <= pwdata[8*i +: 8];
    end
  end

  // Output decode from registers
  always_comb begin
    pready  = (state == ACCESS) && (cnt == '0);
    pslverr = pready && err_r;
    prdata  = (pready && !wr_r) ? prdata_r : '0;
  end

endmodule
